// File: rtl/ex_stage_if.sv
// Handshake bundle for the execute stage: operation-in channel and result-out channel.
// The stage sits on the slave modport; the producer/consumer side uses master.
interface ex_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_alucontrol;
  logic [4:0]       in_rd;
  logic             in_regwrite;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic [4:0]       out_rd;
  logic             out_regwrite;
  logic             out_illegal;

  modport master (
    output in_valid, in_a, in_b, in_alucontrol, in_rd, in_regwrite, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_rd, out_regwrite, out_illegal
  );

  modport slave (
    input  in_valid, in_a, in_b, in_alucontrol, in_rd, in_regwrite, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_rd, out_regwrite, out_illegal
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU feeding a two-entry (main + skid) output buffer.
// Ready/valid are decoded from the state register only, so no in-to-out ready path exists.
module ex_stage #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        resetn,
  ex_stage_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [4:0]       rd;
    logic             regwrite;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q;
  entry_t main_q;
  entry_t skid_q;
  entry_t new_entry;
  logic   accept;
  logic   transfer;

  always_comb begin
    new_entry          = '0;
    new_entry.rd       = bus.in_rd;
    new_entry.regwrite = bus.in_regwrite;
    unique case (bus.in_alucontrol)
      3'b000: new_entry.result = bus.in_a + bus.in_b;
      3'b001: new_entry.result = bus.in_a - bus.in_b;
      3'b010: new_entry.result = bus.in_a & bus.in_b;
      3'b011: new_entry.result = bus.in_a | bus.in_b;
      3'b100: new_entry.result = bus.in_a ^ bus.in_b;
      3'b101: new_entry.result[0] = $signed(bus.in_a) < $signed(bus.in_b);
      default: new_entry.illegal = 1'b1;
    endcase
    new_entry.zero = (new_entry.result == '0);
  end

  assign bus.in_ready  = (state_q != StTwo);
  assign bus.out_valid = (state_q != StEmpty);
  assign accept        = bus.in_valid & bus.in_ready;
  assign transfer      = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q  <= new_entry;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (accept && transfer) begin
            main_q <= new_entry;
          end else if (accept) begin
            skid_q  <= new_entry;
            state_q <= StTwo;
          end else if (transfer) begin
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          // in_ready is low here, so in_valid is deliberately not looked at
          if (transfer) begin
            main_q  <= skid_q;
            state_q <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign bus.out_result   = main_q.result;
  assign bus.out_zero     = main_q.zero;
  assign bus.out_rd       = main_q.rd;
  assign bus.out_regwrite = main_q.regwrite;
  assign bus.out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vectors with literal expectations plus a queue-based
// reference model compared against the outputs on every clock.
`timescale 1ns/1ps
module tb_ex_stage;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ex_stage_if #(.WIDTH(W)) bus ();

  ex_stage #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [W-1:0] result;
    logic         zero;
    logic [4:0]   rd;
    logic         regwrite;
    logic         illegal;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  int   popped = 0;
  int   pushed = 0;
  bit   acc_last = 0;
  bit   m_acc;
  bit   m_xfer;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] code, input logic [4:0] rd,
                                 input logic rw);
    exp_t e;
    e.rd = rd;
    e.regwrite = rw;
    e.illegal = 1'b0;
    case (code)
      3'd0: e.result = a + b;
      3'd1: e.result = a - b;
      3'd2: e.result = a & b;
      3'd3: e.result = a | b;
      3'd4: e.result = a ^ b;
      3'd5: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        e.result = '0;
        e.illegal = 1'b1;
      end
    endcase
    e.zero = (e.result == 0);
    return e;
  endfunction

  // Reference: a FIFO of at most two results; ready/valid follow its occupancy.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      acc_last = 1'b0;
    end else begin
      m_acc  = bus.in_valid && (q.size() < 2);
      m_xfer = (q.size() > 0) && bus.out_ready;
      if (m_xfer) begin
        void'(q.pop_front());
        popped++;
      end
      if (m_acc) begin
        q.push_back(model(bus.in_a, bus.in_b, bus.in_alucontrol, bus.in_rd, bus.in_regwrite));
        pushed++;
      end
      acc_last = m_acc;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("out_result", bus.out_result, q[0].result);
        chk("out_zero", 32'(bus.out_zero), 32'(q[0].zero));
        chk("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
        chk("out_regwrite", 32'(bus.out_regwrite), 32'(q[0].regwrite));
        chk("out_illegal", 32'(bus.out_illegal), 32'(q[0].illegal));
      end
    end
  end

  task automatic put(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] code,
                     input logic [4:0] rd, input logic rw);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_alucontrol = code;
    bus.in_rd = rd;
    bus.in_regwrite = rw;
  endtask

  // Present one op at a negedge; returns one cycle after its acceptance edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] code,
                      input logic [4:0] rd, input logic rw);
    @(negedge clk);
    put(a, b, code, rd, rw);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, " out_result"}, bus.out_result, 32'd0);
    chk({tag, " out_zero"}, 32'(bus.out_zero), 32'd0);
    chk({tag, " out_rd"}, 32'(bus.out_rd), 32'd0);
    chk({tag, " out_regwrite"}, 32'(bus.out_regwrite), 32'd0);
    chk({tag, " out_illegal"}, 32'(bus.out_illegal), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int n_ops;
    int budget;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_alucontrol = '0;
    bus.in_rd = '0;
    bus.in_regwrite = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    resetn = 1'b1;

    // Single ops, out_ready held high: one-cycle latency
    send(32'd5, 32'd7, 3'b001, 5'd3, 1'b1);
    chk("sub valid", 32'(bus.out_valid), 32'd1);
    chk("sub result", bus.out_result, 32'hFFFF_FFFE);
    chk("sub zero", 32'(bus.out_zero), 32'd0);
    chk("sub rd", 32'(bus.out_rd), 32'd3);

    send(32'h8000_0000, 32'd1, 3'b101, 5'd4, 1'b1);
    chk("slt result", bus.out_result, 32'd1);

    send(32'hFFFF_FFFF, 32'd1, 3'b000, 5'd5, 1'b1);
    chk("add wrap result", bus.out_result, 32'd0);
    chk("add wrap zero", 32'(bus.out_zero), 32'd1);

    send(32'h1234, 32'h5678, 3'b110, 5'd9, 1'b1);
    chk("ill result", bus.out_result, 32'd0);
    chk("ill illegal", 32'(bus.out_illegal), 32'd1);
    chk("ill zero", 32'(bus.out_zero), 32'd1);
    chk("ill rd", 32'(bus.out_rd), 32'd9);
    chk("ill regwrite", 32'(bus.out_regwrite), 32'd1);

    // Back-pressure: fill main + skid, third op must wait
    @(negedge clk);
    bus.out_ready = 1'b0;
    put(32'd1, 32'd2, 3'b000, 5'd1, 1'b1);
    @(negedge clk);
    chk("bp in_ready one", 32'(bus.in_ready), 32'd1);
    put(32'hF0, 32'h3C, 3'b010, 5'd2, 1'b0);
    @(negedge clk);
    chk("bp in_ready two", 32'(bus.in_ready), 32'd0);
    put(32'hFF, 32'h0F, 3'b100, 5'd3, 1'b1);
    @(negedge clk);
    chk("bp hold ready", 32'(bus.in_ready), 32'd0);
    chk("bp hold result", bus.out_result, 32'd3);
    chk("bp hold rd", 32'(bus.out_rd), 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("drain 2 result", bus.out_result, 32'h30);
    chk("drain 2 regwrite", 32'(bus.out_regwrite), 32'd0);
    chk("drain ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("drain 3 result", bus.out_result, 32'hF0);
    chk("drain 3 rd", 32'(bus.out_rd), 32'd3);
    @(negedge clk);
    chk("drained valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset while two entries are held
    bus.out_ready = 1'b0;
    put(32'd10, 32'd20, 3'b011, 5'd7, 1'b1);
    @(negedge clk);
    put(32'd30, 32'd40, 3'b000, 5'd8, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre-reset two", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk_reset_outputs("mid");
    @(negedge clk);
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("no stale valid", 32'(bus.out_valid), 32'd0);
    send(32'd9, 32'd4, 3'b001, 5'd11, 1'b0);
    chk("post-reset result", bus.out_result, 32'd5);
    chk("post-reset rd", 32'(bus.out_rd), 32'd11);

    // Random valid/ready traffic against the reference queue
    @(negedge clk);
    popped = 0;
    pushed = 0;
    sent = 0;
    n_ops = 10000;
    while (sent < n_ops || (bus.in_valid && !acc_last)) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      if (!bus.in_valid || acc_last) begin
        if (sent < n_ops && $urandom_range(0, 9) < 7) begin
          put($urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom(),
              $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom(),
              3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
          sent++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    budget = 0;
    while (q.size() > 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    chk("drain bound", 32'(q.size()), 32'd0);
    chk("pushed count", 32'(pushed), 32'(n_ops));
    chk("popped count", 32'(popped), 32'(n_ops));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
